// File: rtl/door_controller.sv
// Elevator car door sequencer: CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED on door_clk ticks.
// Optional nudge mode (buzzer, obstruction ignored after repeated reopens) is enabled by DOOR_NUDGE_EN.
module door_controller #(
    parameter int unsigned OPEN_TICKS  = 2,
    parameter int unsigned HOLD_TICKS  = 3,
    parameter int unsigned CLOSE_TICKS = 2,
    parameter int unsigned MAX_REOPEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       door_clk,
    input  logic       arrived,
    input  logic       open_btn,
    input  logic       close_btn,
    input  logic       obstruction,
    input  logic       weight_limit_exceeded,
    output logic       motor_open,
    output logic       motor_close,
    output logic       door_closed,
    output logic       move_handler,
    output logic       buzzer,
    output logic [1:0] door_state
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned RC_W  = 3;

    localparam logic [CNT_W-1:0] OPEN_T  = CNT_W'(OPEN_TICKS);
    localparam logic [CNT_W-1:0] HOLD_T  = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] CLOSE_T = CNT_W'(CLOSE_TICKS);

    // Parameter range guards, evaluated at elaboration only.
    if (OPEN_TICKS < 1 || OPEN_TICKS > 15) begin : g_bad_open
        $error("door_controller: OPEN_TICKS must be 1..15");
    end
    if (HOLD_TICKS < 1 || HOLD_TICKS > 15) begin : g_bad_hold
        $error("door_controller: HOLD_TICKS must be 1..15");
    end
    if (CLOSE_TICKS < 1 || CLOSE_TICKS > 15) begin : g_bad_close
        $error("door_controller: CLOSE_TICKS must be 1..15");
    end
    if (MAX_REOPEN < 1 || MAX_REOPEN > 7) begin : g_bad_reopen
        $error("door_controller: MAX_REOPEN must be 1..7");
    end

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   tick_cnt;
    logic [CNT_W-1:0]   tick_cnt_next;
    logic [CNT_W-1:0]   tick_inc;
    logic               door_clk_d;
    logic               tick;
    logic               nudge_active;

    // One tick per rising edge of door_clk, however long it stays high.
    assign tick     = door_clk & ~door_clk_d;
    assign tick_inc = tick_cnt + CNT_W'(1);

`ifdef DOOR_NUDGE_EN
    localparam logic [RC_W-1:0] MAX_RC = RC_W'(MAX_REOPEN);

    logic [RC_W-1:0] reopen_cnt;
    logic [RC_W-1:0] reopen_cnt_next;
    logic            nudge;
    logic            nudge_next;

    assign nudge_active = nudge;
`else
    assign nudge_active = 1'b0;
`endif

    // Next-state, tick counter and reopen bookkeeping.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
`ifdef DOOR_NUDGE_EN
        reopen_cnt_next = reopen_cnt;
        nudge_next      = nudge;
`endif
        case (state)
            ST_CLOSED: begin
                if (arrived || open_btn) begin
                    state_next = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (tick) begin
                    if (tick_inc >= OPEN_T) begin
                        state_next = ST_OPEN;
                    end else begin
                        tick_cnt_next = tick_inc;
                    end
                end
            end
            ST_OPEN: begin
                if (weight_limit_exceeded || obstruction || open_btn) begin
                    tick_cnt_next = '0;
                end else if (close_btn) begin
                    state_next = ST_CLOSING;
                end else if (tick) begin
                    if (tick_inc >= HOLD_T) begin
                        state_next = ST_CLOSING;
                    end else begin
                        tick_cnt_next = tick_inc;
                    end
                end
            end
            ST_CLOSING: begin
                if (weight_limit_exceeded) begin
                    state_next = ST_OPENING;
                end else if ((obstruction || open_btn) && !nudge_active) begin
                    state_next = ST_OPENING;
`ifdef DOOR_NUDGE_EN
                    if (obstruction && (reopen_cnt != MAX_RC)) begin
                        reopen_cnt_next = reopen_cnt + RC_W'(1);
                    end
`endif
                end else if (tick) begin
                    if (tick_inc >= CLOSE_T) begin
                        state_next = ST_CLOSED;
`ifdef DOOR_NUDGE_EN
                        reopen_cnt_next = '0;
`endif
                    end else begin
                        tick_cnt_next = tick_inc;
                    end
                end
            end
            default: begin
                state_next = ST_CLOSED;
            end
        endcase

        // Every state change restarts the count, so a reopen always takes the full OPEN_TICKS.
        if (state_next != state) begin
            tick_cnt_next = '0;
        end

`ifdef DOOR_NUDGE_EN
        if ((state_next == ST_CLOSING) && (state != ST_CLOSING) && (reopen_cnt == MAX_RC)) begin
            nudge_next = 1'b1;
        end
        if (state_next == ST_CLOSED) begin
            nudge_next = 1'b0;
        end
`endif
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLOSED;
            tick_cnt   <= '0;
            door_clk_d <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_cnt_next;
            door_clk_d <= door_clk;
        end
    end

`ifdef DOOR_NUDGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reopen_cnt <= '0;
            nudge      <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            reopen_cnt <= reopen_cnt_next;
            nudge      <= nudge_next;
            buzzer     <= nudge_next;
        end
    end
`else
    assign buzzer = 1'b0;
`endif

    // Registered Moore outputs, loaded from the next state so they track the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            motor_open   <= 1'b0;
            motor_close  <= 1'b0;
            door_closed  <= 1'b1;
            move_handler <= 1'b0;
            door_state   <= 2'd0;
        end else begin
            motor_open   <= (state_next == ST_OPENING);
            motor_close  <= (state_next == ST_CLOSING);
            door_closed  <= (state_next == ST_CLOSED);
            move_handler <= (state == ST_CLOSING) && (state_next == ST_CLOSED);
            door_state   <= 2'(state_next);
        end
    end

    a_motor_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(motor_open && motor_close));
    a_move_closed : assert property (@(posedge clk) disable iff (!rst_n)
        move_handler |-> door_closed);

endmodule
